// File: rtl/io_pio_ctrl.sv
// rtl/io_pio_ctrl.sv - debounced buttons with press-edge irq and LED enable/PWM slave
// Per-LED PWM brightness is built only when IO_PIO_PWM_EN is defined.
module io_pio_ctrl #(
  parameter int NUM_BTN         = 1,
  parameter int NUM_LED         = 4,
  parameter int DEBOUNCE_CYCLES = 1500000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int PWM_BITS        = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] button,
  output logic [NUM_LED-1:0] leds,
  input  logic [3:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Synchronisers reset to the released pin level so nothing counts after reset.
  localparam logic [NUM_BTN-1:0] PIN_IDLE = {NUM_BTN{BTN_ACTIVE_LOW != 0}};

  logic [NUM_BTN-1:0] sync1, sync2, sync, stable, accept, press, w1c;
  logic [CW-1:0]      cnt [NUM_BTN];
  logic [NUM_BTN-1:0] edge_reg, mask_reg;
  logic [NUM_LED-1:0] led_en;
  logic [31:0]        rdata;
  logic               wr_edge, wr_mask, wr_len;
  logic               unused_wdata;

  assign unused_wdata = ^avs_writedata;
  assign sync    = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign wr_edge = avs_write && (avs_address == 4'd1);
  assign wr_mask = avs_write && (avs_address == 4'd2);
  assign wr_len  = avs_write && (avs_address == 4'd3);
  assign w1c     = wr_edge ? avs_writedata[NUM_BTN-1:0] : '0;

  always_comb begin
    accept = '0;
    for (int b = 0; b < NUM_BTN; b++)
      accept[b] = (sync[b] != stable[b]) && (cnt[b] == CNT_LAST);
  end
  assign press = accept & sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= PIN_IDLE;
      sync2  <= PIN_IDLE;
      stable <= '0;
      for (int b = 0; b < NUM_BTN; b++) cnt[b] <= '0;
    end else begin
      sync1  <= button;
      sync2  <= sync1;
      stable <= (stable & ~accept) | (sync & accept);
      for (int b = 0; b < NUM_BTN; b++) begin
        if ((sync[b] == stable[b]) || accept[b]) cnt[b] <= '0;
        else                                     cnt[b] <= cnt[b] + CW'(1);
      end
    end
  end

  // A press landing in the same cycle as a W1C of that bit survives the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_reg     <= '0;
      mask_reg     <= '0;
      led_en       <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      edge_reg <= (edge_reg & ~w1c) | press;
      if (wr_mask) mask_reg <= avs_writedata[NUM_BTN-1:0];
      if (wr_len)  led_en   <= avs_writedata[NUM_LED-1:0];
      irq <= |(edge_reg & mask_reg);
      if (avs_read) avs_readdata <= rdata;
    end
  end

`ifdef IO_PIO_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty   [NUM_LED];
  logic [PWM_BITS-1:0] shadow [NUM_LED];
  logic [NUM_LED-1:0]  led_next;

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LED; i++)
      led_next[i] = led_en[i] && ((shadow[i] == '1) || (pwm_cnt < shadow[i]));
  end

  // Shadows reload only on the wrap so a duty write never cuts a period short.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      leds    <= '0;
      for (int i = 0; i < NUM_LED; i++) begin
        duty[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      leds    <= led_next;
      for (int i = 0; i < NUM_LED; i++) begin
        if (avs_write && (avs_address == 4'(8 + i))) duty[i] <= avs_writedata[PWM_BITS-1:0];
        if (pwm_cnt == '1) shadow[i] <= duty[i];
      end
    end
  end
`else
  localparam int unused_pwm_bits = PWM_BITS;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) leds <= '0;
    else          leds <= led_en;
  end
`endif

  always_comb begin
    rdata = '0;
    case (avs_address)
      4'd0:    rdata[NUM_BTN-1:0] = stable;
      4'd1:    rdata[NUM_BTN-1:0] = edge_reg;
      4'd2:    rdata[NUM_BTN-1:0] = mask_reg;
      4'd3:    rdata[NUM_LED-1:0] = led_en;
      default: ;
    endcase
`ifdef IO_PIO_PWM_EN
    for (int i = 0; i < NUM_LED; i++)
      if (avs_address == 4'(8 + i)) rdata[PWM_BITS-1:0] = duty[i];
`endif
  end

endmodule

// File: tb/tb_io_pio_ctrl.sv
// tb/tb_io_pio_ctrl.sv - directed self-checking bench for io_pio_ctrl
module tb_io_pio_ctrl;
  localparam int NB = 2;
  localparam int NL = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] button = 2'b11;
  logic [NL-1:0] leds;
  logic [3:0]    avs_address = 4'd0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = 32'd0;
  logic [31:0]   avs_readdata;
  logic          irq;

  int checks = 0;
  int failures = 0;

  io_pio_ctrl #(
    .NUM_BTN(NB), .NUM_LED(NL), .DEBOUNCE_CYCLES(16), .BTN_ACTIVE_LOW(1), .PWM_BITS(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .button(button), .leds(leds),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick(1);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick(1);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tick(3);
    checks++; if (leds !== 4'h0) begin failures++; $display("FAIL reset_leds got=%0h exp=0", leds); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", avs_readdata); end
    reset_n = 1'b1;
    tick(3);
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_state got=%0h exp=0", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_after got=%0b exp=0", irq); end
  endtask

  task automatic test_press();
    logic [31:0] d;
    int first_st = -1;
    int first_irq = -1;
    bus_write(4'd2, 32'h1);
    bus_read(4'd2, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL mask_rd got=%0h exp=1", d); end
    avs_address = 4'd0; avs_read = 1'b1;
    button[0] = 1'b0;
    // STATE updates 18 edges after the pin change; readdata shows it one edge later.
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (first_st < 0 && avs_readdata[0]) first_st = k;
      if (first_irq < 0 && irq) first_irq = k;
    end
    avs_read = 1'b0;
    checks++; if (first_st != 19) begin failures++; $display("FAIL press_latency got=%0d exp=19", first_st); end
    checks++; if (first_irq != 19) begin failures++; $display("FAIL press_irq got=%0d exp=19", first_irq); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL press_edge got=%0h exp=1", d); end
    button[0] = 1'b1;
    tick(25);
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL release_state got=%0h exp=0", d); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL release_no_edge got=%0h exp=1", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    repeat (5) begin
      button[1] = 1'b0; tick(10);
      button[1] = 1'b1; tick(10);
    end
    tick(10);
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL glitch_state got=%0h exp=0", d); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL glitch_edge got=%0h exp=1", d); end
    button[1] = 1'b0;
    tick(20);
    bus_read(4'd0, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL hold_state got=%0h exp=2", d); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL hold_edge got=%0h exp=3", d); end
    button[1] = 1'b1;
    tick(25);
    bus_write(4'd1, 32'h2);
    bus_read(4'd1, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL w1c_bit1 got=%0h exp=1", d); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    button[0] = 1'b0;
    tick(17);
    bus_write(4'd1, 32'h1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL coll_irq got=%0b exp=1", irq); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL coll_edge got=%0h exp=1", d); end
    bus_read(4'd0, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL coll_state got=%0h exp=1", d); end
    tick(3);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL coll_irq_hold got=%0b exp=1", irq); end
    bus_write(4'd1, 32'h1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL clr_irq_lat got=%0b exp=1", irq); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq got=%0b exp=0", irq); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL clr_edge got=%0h exp=0", d); end
    button[0] = 1'b1;
    tick(25);
  endtask

`ifdef IO_PIO_PWM_EN
  task automatic test_pwm();
    logic [31:0] d;
    int on_cnt[NL];
    int exp_on[NL] = '{4, 0, 16, 8};
    int a, b, k0;
    logic prev;
    bus_write(4'd3, 32'hF);
    bus_write(4'd8, 32'd4);
    bus_write(4'd9, 32'd0);
    bus_write(4'd10, 32'd15);
    bus_write(4'd11, 32'd8);
    tick(20);
    for (int i = 0; i < NL; i++) on_cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NL; i++) if (leds[i]) on_cnt[i]++;
      tick(1);
    end
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (on_cnt[i] != exp_on[i]) begin
        failures++; $display("FAIL pwm_on_led%0d got=%0d exp=%0d", i, on_cnt[i], exp_on[i]);
      end
    end
    prev = leds[0]; k0 = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (!prev && leds[0]) begin k0 = k; break; end
      prev = leds[0];
    end
    checks++;
    if (k0 < 0) begin
      failures++; $display("FAIL pwm_sync got=timeout exp=rise");
    end else begin
      a = 1; b = 0;
      for (int k = 1; k < 32; k++) begin
        if (k == 3) begin avs_address = 4'd8; avs_writedata = 32'd12; avs_write = 1'b1; end
        tick(1);
        avs_write = 1'b0;
        if (leds[0]) begin if (k < 16) a++; else b++; end
      end
      checks++; if (a != 4) begin failures++; $display("FAIL pwm_old_period got=%0d exp=4", a); end
      checks++; if (b != 12) begin failures++; $display("FAIL pwm_new_period got=%0d exp=12", b); end
    end
    bus_read(4'd8, d);
    checks++; if (d !== 32'd12) begin failures++; $display("FAIL duty_rd got=%0h exp=c", d); end
    bus_write(4'd12, 32'hF);
    bus_read(4'd12, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL duty_oor got=%0h exp=0", d); end
  endtask
`else
  task automatic test_led_direct();
    logic [31:0] d;
    bus_write(4'd3, 32'h5);
    checks++; if (leds !== 4'h0) begin failures++; $display("FAIL led_lat got=%0h exp=0", leds); end
    tick(1);
    checks++; if (leds !== 4'h5) begin failures++; $display("FAIL led_en got=%0h exp=5", leds); end
    bus_read(4'd3, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL led_en_rd got=%0h exp=5", d); end
    bus_write(4'd8, 32'h7);
    bus_read(4'd8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL duty_absent got=%0h exp=0", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_w1c_collision();
`ifdef IO_PIO_PWM_EN
    test_pwm();
`else
    test_led_direct();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
